seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 10000: clock cycles per digit slot; legal range BLANK+1..65535.
REQ-002 SHALL have parameter BLANK, default 16: blanking cycles at the start of each slot; legal range 1..DIV-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port data  input  32  eight hex nibbles; nibble k (data[4k+3:4k]) is shown on digit k.
REQ-007 SHALL have port digit_mask  input  8  bit k=1 means digit k is lit during its slot.
REQ-008 SHALL have port a  output  3  digit select to the 3-to-8 decoder.
REQ-009 SHALL have port e1_n  output  1  decoder enable, active-low.
REQ-010 SHALL have port e2_n  output  1  decoder enable, active-low.
REQ-011 SHALL have port e3  output  1  decoder enable, active-high.
REQ-012 SHALL have port hex  output  4  nibble for the currently selected digit.
REQ-013 SHALL have port frame  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement states IDLE, BLANK and SHOW, plus a slot counter cnt (16 bits) and a digit index dig (3 bits).
REQ-016 In IDLE: e1_n=1, e2_n=1, e3=0, a=0, hex=0; if en=1, SHALL go to BLANK next cycle with dig=0, cnt=0, and capture data and digit_mask into shadow registers.
REQ-017 In BLANK: decoder disabled (e1_n=e2_n=1, e3=0); a=dig; hex=shadow nibble[dig]; after BLANK cycles, SHALL go to SHOW.
REQ-018 In SHOW: a=dig; hex=shadow nibble[dig]; e1_n=e2_n=0 and e3=1 only if shadow_mask[dig]=1, otherwise decoder disabled.
REQ-019 Slot length SHALL be exactly DIV cycles: BLANK cycles in BLANK, then DIV-BLANK cycles in SHOW.
REQ-020 At the end of a slot, SHALL set dig=dig+1 (mod 8) and cnt=0, and return to BLANK.
REQ-021 On the wrap from dig=7 to dig=0, SHALL pulse frame=1 for exactly that one cycle (the first BLANK cycle of digit 0) and reload the shadow data and mask from the inputs.
REQ-022 Changes to data or digit_mask mid-frame SHALL be invisible until the next wrap (no tearing).
REQ-023 A masked digit SHALL still consume its full DIV-cycle slot, so that frame period is always 8*DIV cycles.
REQ-024 If en=0 in BLANK or SHOW, the block SHALL enter IDLE on the next edge, with all IDLE outputs, abandoning the slot; frame SHALL NOT pulse.
REQ-025 Re-enabling from IDLE SHALL always restart at digit 0 with a fresh capture (REQ-016).
REQ-026 Decoder enables SHALL never be asserted in the same cycle that a changes value.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL enter IDLE with cnt=0, dig=0, shadows=0, a=0, e1_n=1, e2_n=1, e3=0, hex=0 and frame=0, overriding en, including mid-slot.
REQ-028 The first cycle after reset release with en=1 SHALL behave as REQ-016.

Verification (DIV=8, BLANK=2)
REQ-029 Reset while en=1 -> outputs a=0, e1_n=1, e2_n=1, e3=0, hex=0, frame=0 at the first edge with rst_n low.
REQ-030 data=32'h76543210, mask=8'hFF, en=1 -> each slot gives 2 cycles disabled then 6 cycles enabled with a=k, hex=k; a sequence 0..7; frame pulses every 64 cycles.
REQ-031 mask=8'b1010_1010 -> e3 stays 0 during the slots for digits 0, 2, 4 and 6; frame period stays 64 cycles.
REQ-032 data changes to 32'hFFFFFFFF during digit 3 -> digits 3-7 still show the old nibbles; digit 0 of the next frame shows F.
REQ-033 en dropped during SHOW of digit 5 -> next cycle IDLE with enables off and no frame pulse; en re-raised -> scan resumes at a=0.
REQ-034 Checker over all tests -> no cycle with decoder enabled (e1_n=0, e2_n=0, e3=1) where a differs from the previous cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit hex display scanner driving a 3-to-8 decoder.
// Latency: every output is registered and describes the state held in the same cycle.
// Backpressure: none; en=0 abandons the scan on the next edge, rst_n (sync, active-low) overrides all.
//
// Ports:
//   clk, rst_n        - sole clock; synchronous active-low reset
//   en                - scan enable
//   data, digit_mask  - eight hex nibbles and per-digit light mask, sampled once per frame
//   a, e1_n, e2_n, e3 - decoder select and enables (e1_n/e2_n active-low, e3 active-high)
//   hex               - nibble of the selected digit
//   frame             - one-cycle pulse on the first cycle of digit 0 after a 7->0 wrap
module seg_scan_ctrl #(
    parameter int DIV   = 10000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  digit_mask,
    output logic [2:0]  a,
    output logic        e1_n,
    output logic        e2_n,
    output logic        e3,
    output logic [3:0]  hex,
    output logic        frame
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
    localparam logic [15:0] CNT_BLANK = 16'(BLANK);

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_dig;
    logic [31:0] r_shadow_data;
    logic [7:0]  r_shadow_mask;

    logic [1:0]  w_nxt_state;
    logic [15:0] w_nxt_cnt;
    logic [2:0]  w_nxt_dig;
    logic [31:0] w_nxt_data;
    logic [7:0]  w_nxt_mask;
    logic        w_nxt_frame;
    logic [15:0] w_cnt_inc;
    logic [31:0] w_nib_shift;
    logic [3:0]  w_nxt_nib;
    logic        w_nxt_lit;

    assign w_cnt_inc = r_cnt + 16'd1;

    // Next-state logic for the scan sequencer.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_dig   = r_dig;
        w_nxt_data  = r_shadow_data;
        w_nxt_mask  = r_shadow_mask;
        w_nxt_frame = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_nxt_state = S_BLANK;
                    w_nxt_cnt   = 16'd0;
                    w_nxt_dig   = 3'd0;
                    w_nxt_data  = data;
                    w_nxt_mask  = digit_mask;
                end
            end
            default: begin
                if (!en) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = 16'd0;
                    w_nxt_dig   = 3'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_state = S_BLANK;
                    w_nxt_cnt   = 16'd0;
                    w_nxt_dig   = r_dig + 3'd1;
                    // Shadows only reload on the frame wrap so a frame never tears.
                    if (r_dig == 3'd7) begin
                        w_nxt_frame = 1'b1;
                        w_nxt_data  = data;
                        w_nxt_mask  = digit_mask;
                    end
                end else begin
                    w_nxt_cnt   = w_cnt_inc;
                    w_nxt_state = (w_cnt_inc < CNT_BLANK) ? S_BLANK : S_SHOW;
                end
            end
        endcase
    end

    // Output values are derived from the next state so the registered
    // outputs line up with the state they describe.
    assign w_nib_shift = w_nxt_data >> {w_nxt_dig, 2'b00};
    assign w_nxt_nib   = w_nib_shift[3:0];
    assign w_nxt_lit   = (w_nxt_state == S_SHOW) && w_nxt_mask[w_nxt_dig];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_dig         <= 3'd0;
            r_shadow_data <= 32'd0;
            r_shadow_mask <= 8'd0;
            a             <= 3'd0;
            e1_n          <= 1'b1;
            e2_n          <= 1'b1;
            e3            <= 1'b0;
            hex           <= 4'd0;
            frame         <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_dig         <= w_nxt_dig;
            r_shadow_data <= w_nxt_data;
            r_shadow_mask <= w_nxt_mask;
            frame         <= w_nxt_frame;
            if (w_nxt_state == S_IDLE) begin
                a   <= 3'd0;
                hex <= 4'd0;
            end else begin
                a   <= w_nxt_dig;
                hex <= w_nxt_nib;
            end
            // Enables only come up after at least one blanking cycle, so
            // they are never high on a cycle where a moves.
            e1_n <= !w_nxt_lit;
            e2_n <= !w_nxt_lit;
            e3   <= w_nxt_lit;
        end
    end

endmodule
